// File: rtl/mannix_mem_pkg.sv
// Shared types and constants for the memory-farm read client.
// Line lengths, request sizes and buffered line records live here.
package mannix_mem_pkg;

    localparam int ADDR_WIDTH  = 19;
    localparam int LINE_BYTES  = 32;
    localparam int LINE_BITS   = 8 * LINE_BYTES;
    localparam int SIZE_WIDTH  = 5;
    localparam int BYTES_WIDTH = 6;
    localparam int REM_WIDTH   = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } rd_state_e;

    typedef struct packed {
        logic [LINE_BITS-1:0]   data;
        logic [BYTES_WIDTH-1:0] bytes;
        logic                   last;
    } line_s;

    // Bytes carried by the next line: the remaining count, capped at one full line.
    function automatic logic [BYTES_WIDTH-1:0] line_len_f(input logic [REM_WIDTH-1:0] rem);
        logic [BYTES_WIDTH-1:0] len;
        if (rem >= REM_WIDTH'(LINE_BYTES)) begin
            len = BYTES_WIDTH'(LINE_BYTES);
        end else begin
            len = rem[BYTES_WIDTH-1:0];
        end
        return len;
    endfunction

endpackage

// File: rtl/mem_client_fifo.sv
// First-word fall-through line buffer between the memory farm and the compute engine.
// The head entry is presented directly from storage; count reports occupancy.
module mem_client_fifo
    import mannix_mem_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  line_s            push_line,
    input  logic             pop,
    output line_s            head,
    output logic             head_valid,
    output logic [CNT_W-1:0] count
);

    line_s            mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Qualify push/pop against occupancy so the pointers never over/underrun.
    always_comb begin
        do_pop_s  = pop && (count_r != CNT_W'(0));
        do_push_s = push && ((count_r != CNT_W'(DEPTH)) || do_pop_s);
    end

    // Line storage write port.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_line;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head       = mem_r[rd_ptr_r];
    assign head_valid = (count_r != CNT_W'(0));
    assign count      = count_r;

endmodule

// File: rtl/mem_client_reader.sv
// Initiator side of the mem_intf_read protocol: splits a read job into line requests,
// keeps one request outstanding and streams returned lines out through a small FIFO.
module mem_client_reader
    import mannix_mem_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 1023
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   job_valid,
    output logic                   job_ready,
    input  logic [ADDR_WIDTH-1:0]  job_addr,
    input  logic [REM_WIDTH-1:0]   job_bytes,
    output logic                   job_done,
    output logic                   job_err,
    output logic                   mem_req,
    output logic [ADDR_WIDTH-1:0]  mem_start_addr,
    output logic [SIZE_WIDTH-1:0]  mem_size_bytes,
    input  logic                   mem_valid,
    input  logic [LINE_BITS-1:0]   mem_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LINE_BITS-1:0]   out_data,
    output logic [BYTES_WIDTH-1:0] out_bytes,
    output logic                   out_last
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int WD_W  = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

    rd_state_e              state_r;
    rd_state_e              state_nxt_s;
    logic [ADDR_WIDTH-1:0]  addr_r;
    logic [REM_WIDTH-1:0]   rem_r;
    logic [WD_W-1:0]        wd_r;
    logic                   mem_req_r;
    logic [ADDR_WIDTH-1:0]  mem_start_addr_r;
    logic [SIZE_WIDTH-1:0]  mem_size_r;
    logic                   job_done_r;
    logic                   job_err_r;

    logic                   accept_s;
    logic                   can_issue_s;
    logic                   push_s;
    logic                   timeout_s;
    logic [BYTES_WIDTH-1:0] len_s;
    line_s                  push_line_s;
    line_s                  head_s;
    logic                   head_valid_s;
    logic [CNT_W-1:0]       fifo_count_s;

    // Per-state control decode and next-state selection.
    always_comb begin
        state_nxt_s = state_r;
        push_s      = 1'b0;
        accept_s    = job_valid && (state_r == IDLE);
        // Issuing only with a free slot is what makes an overflow impossible.
        can_issue_s = (fifo_count_s < CNT_W'(FIFO_DEPTH));
        timeout_s   = (wd_r == WD_MAX);
        len_s       = line_len_f(rem_r);
        push_line_s = '{data: mem_data, bytes: len_s, last: (rem_r <= REM_WIDTH'(LINE_BYTES))};
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = (job_bytes == REM_WIDTH'(0)) ? DONE : ISSUE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ISSUE: begin
                if (can_issue_s) begin
                    state_nxt_s = WAIT;
                end else begin
                    state_nxt_s = ISSUE;
                end
            end
            WAIT: begin
                if (mem_valid) begin
                    push_s      = 1'b1;
                    state_nxt_s = push_line_s.last ? DONE : ISSUE;
                end else if (timeout_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Job bookkeeping, request registers and the line watchdog.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r          <= IDLE;
            addr_r           <= ADDR_WIDTH'(0);
            rem_r            <= REM_WIDTH'(0);
            wd_r             <= WD_W'(0);
            mem_req_r        <= 1'b0;
            mem_start_addr_r <= ADDR_WIDTH'(0);
            mem_size_r       <= SIZE_WIDTH'(0);
            job_done_r       <= 1'b0;
            job_err_r        <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            job_done_r <= (state_r == DONE);
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        addr_r    <= job_addr;
                        rem_r     <= job_bytes;
                        job_err_r <= 1'b0;
                    end
                end
                ISSUE: begin
                    if (can_issue_s) begin
                        mem_req_r        <= 1'b1;
                        mem_start_addr_r <= addr_r;
                        mem_size_r       <= SIZE_WIDTH'(len_s - BYTES_WIDTH'(1));
                        wd_r             <= WD_W'(0);
                    end
                end
                WAIT: begin
                    if (mem_valid) begin
                        mem_req_r <= 1'b0;
                        rem_r     <= rem_r - REM_WIDTH'(len_s);
                        addr_r    <= addr_r + ADDR_WIDTH'(LINE_BYTES);
                    end else if (timeout_s) begin
                        mem_req_r <= 1'b0;
                        job_err_r <= 1'b1;
                    end else begin
                        wd_r <= wd_r + WD_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    mem_client_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push_s),
        .push_line  (push_line_s),
        .pop        (out_ready),
        .head       (head_s),
        .head_valid (head_valid_s),
        .count      (fifo_count_s)
    );

    assign job_ready      = (state_r == IDLE);
    assign job_done       = job_done_r;
    assign job_err        = job_err_r;
    assign mem_req        = mem_req_r;
    assign mem_start_addr = mem_start_addr_r;
    assign mem_size_bytes = mem_size_r;
    assign out_valid      = head_valid_s;
    assign out_data       = head_s.data;
    assign out_bytes      = head_s.bytes;
    assign out_last       = head_s.last;

endmodule

// File: tb/tb_mem_client_reader.sv
// Directed bench for mem_client_reader: line splitting, address wrap, back-pressure,
// empty jobs, watchdog abort and mid-job reset.
module tb_mem_client_reader;

    logic         clk = 1'b0;
    logic         rst;
    logic         job_valid;
    logic         job_ready;
    logic [18:0]  job_addr;
    logic [15:0]  job_bytes;
    logic         job_done;
    logic         job_err;
    logic         mem_req;
    logic [18:0]  mem_start_addr;
    logic [4:0]   mem_size_bytes;
    logic         mem_valid;
    logic [255:0] mem_data;
    logic         out_valid;
    logic         out_ready;
    logic [255:0] out_data;
    logic [5:0]   out_bytes;
    logic         out_last;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_client_reader #(
        .FIFO_DEPTH (4),
        .TIMEOUT    (15)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .job_valid      (job_valid),
        .job_ready      (job_ready),
        .job_addr       (job_addr),
        .job_bytes      (job_bytes),
        .job_done       (job_done),
        .job_err        (job_err),
        .mem_req        (mem_req),
        .mem_start_addr (mem_start_addr),
        .mem_size_bytes (mem_size_bytes),
        .mem_valid      (mem_valid),
        .mem_data       (mem_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_bytes      (out_bytes),
        .out_last       (out_last)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] line_pat(input int k);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i*32 +: 32] = 32'hC0DE_0000 + (32'(k) << 8) + 32'(i);
        end
        return r;
    endfunction

    task automatic wait_req(output int waited);
        waited = 0;
        while (!mem_req && waited < 50) begin
            tick();
            waited++;
        end
        if (!mem_req) waited = -1;
    endtask

    task automatic pulse_valid(input logic [255:0] d);
        mem_valid = 1'b1;
        mem_data  = d;
        tick();
        mem_valid = 1'b0;
        mem_data  = 256'd0;
    endtask

    task automatic start_job(input logic [18:0] a, input logic [15:0] b);
        job_addr  = a;
        job_bytes = b;
        job_valid = 1'b1;
        tick();
        job_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        checks++; if (job_ready !== 1'b1) begin errors++; $display("FAIL rst_job_ready got %0h exp 1", job_ready); end
        checks++; if (job_done !== 1'b0) begin errors++; $display("FAIL rst_job_done got %0h exp 0", job_done); end
        checks++; if (job_err !== 1'b0) begin errors++; $display("FAIL rst_job_err got %0h exp 0", job_err); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req got %0h exp 0", mem_req); end
        checks++; if (mem_start_addr !== 19'h0) begin errors++; $display("FAIL rst_addr got %0h exp 0", mem_start_addr); end
        checks++; if (mem_size_bytes !== 5'd0) begin errors++; $display("FAIL rst_size got %0d exp 0", mem_size_bytes); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %0h exp 0", out_valid); end
    endtask

    task automatic test_basic();
        int w;
        logic [18:0] ea;
        out_ready = 1'b0;
        start_job(19'h00100, 16'd96);
        for (int k = 0; k < 3; k++) begin
            ea = 19'h00100 + 19'(32 * k);
            wait_req(w);
            checks++; if (w !== 1) begin errors++; $display("FAIL basic_req_delay[%0d] got %0d exp 1", k, w); end
            checks++; if (mem_start_addr !== ea) begin errors++; $display("FAIL basic_addr[%0d] got %0h exp %0h", k, mem_start_addr, ea); end
            checks++; if (mem_size_bytes !== 5'd31) begin errors++; $display("FAIL basic_size[%0d] got %0d exp 31", k, mem_size_bytes); end
            repeat (3) tick();
            checks++; if (mem_req !== 1'b1 || mem_start_addr !== ea) begin errors++; $display("FAIL basic_hold[%0d] got req %0h addr %0h exp req 1 addr %0h", k, mem_req, mem_start_addr, ea); end
            pulse_valid(line_pat(k));
            checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL basic_req_drop[%0d] got %0h exp 0", k, mem_req); end
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid[%0d] got %0h exp 1", k, out_valid); end
            if (k < 2) begin
                checks++; if (job_done !== 1'b0) begin errors++; $display("FAIL basic_early_done[%0d] got %0h exp 0", k, job_done); end
            end
        end
        tick();
        checks++; if (job_done !== 1'b1) begin errors++; $display("FAIL basic_done got %0h exp 1", job_done); end
        tick();
        checks++; if (job_done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %0h exp 0", job_done); end
        checks++; if (job_ready !== 1'b1) begin errors++; $display("FAIL basic_ready got %0h exp 1", job_ready); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (out_valid !== 1'b1 || out_bytes !== 6'd32) begin errors++; $display("FAIL basic_bytes[%0d] got v%0h b%0d exp v1 b32", k, out_valid, out_bytes); end
            checks++; if (out_last !== (k == 2)) begin errors++; $display("FAIL basic_last[%0d] got %0h exp %0h", k, out_last, (k == 2)); end
            checks++; if (out_data !== line_pat(k)) begin errors++; $display("FAIL basic_data[%0d] got %0h exp %0h", k, out_data, line_pat(k)); end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drained got %0h exp 0", out_valid); end
    endtask

    task automatic test_wrap();
        int w;
        logic [18:0] ea [2] = '{19'h7FFF0, 19'h00010};
        logic [4:0]  es [2] = '{5'd31, 5'd7};
        logic [5:0]  eb [2] = '{6'd32, 6'd8};
        start_job(19'h7FFF0, 16'd40);
        for (int k = 0; k < 2; k++) begin
            wait_req(w);
            checks++; if (w < 0) begin errors++; $display("FAIL wrap_no_req[%0d] got %0d exp >=0", k, w); end
            checks++; if (mem_start_addr !== ea[k]) begin errors++; $display("FAIL wrap_addr[%0d] got %0h exp %0h", k, mem_start_addr, ea[k]); end
            checks++; if (mem_size_bytes !== es[k]) begin errors++; $display("FAIL wrap_size[%0d] got %0d exp %0d", k, mem_size_bytes, es[k]); end
            pulse_valid(line_pat(10 + k));
        end
        tick();
        for (int k = 0; k < 2; k++) begin
            checks++; if (out_bytes !== eb[k] || out_last !== (k == 1)) begin errors++; $display("FAIL wrap_line[%0d] got b%0d l%0h exp b%0d l%0h", k, out_bytes, out_last, eb[k], (k == 1)); end
            checks++; if (out_data !== line_pat(10 + k)) begin errors++; $display("FAIL wrap_data[%0d] got %0h exp %0h", k, out_data, line_pat(10 + k)); end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        int w;
        int stray;
        out_ready = 1'b0;
        start_job(19'h01000, 16'd192);
        // Memory answers in the request cycle, so requests should land every 2 cycles.
        for (int k = 0; k < 4; k++) begin
            wait_req(w);
            checks++; if (w !== 1) begin errors++; $display("FAIL b2b_gap[%0d] got %0d exp 1", k, w); end
            checks++; if (mem_start_addr !== 19'h01000 + 19'(32 * k)) begin errors++; $display("FAIL b2b_addr[%0d] got %0h exp %0h", k, mem_start_addr, 19'h01000 + 19'(32 * k)); end
            pulse_valid(line_pat(20 + k));
        end
        stray = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (mem_req) stray++;
        end
        checks++; if (stray !== 0) begin errors++; $display("FAIL b2b_full_stall got %0d req cycles exp 0", stray); end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++; if (out_valid !== 1'b1 || out_data !== line_pat(20 + k) || out_last !== 1'b0) begin errors++; $display("FAIL b2b_line[%0d] got v%0h l%0h d%0h exp v1 l0 d%0h", k, out_valid, out_last, out_data, line_pat(20 + k)); end
            tick();
        end
        out_ready = 1'b0;
        for (int k = 4; k < 6; k++) begin
            wait_req(w);
            checks++; if (w < 0 || mem_start_addr !== 19'h01000 + 19'(32 * k)) begin errors++; $display("FAIL b2b_resume[%0d] got w%0d a%0h exp a%0h", k, w, mem_start_addr, 19'h01000 + 19'(32 * k)); end
            pulse_valid(line_pat(20 + k));
        end
        tick();
        for (int k = 4; k < 6; k++) begin
            checks++; if (out_data !== line_pat(20 + k) || out_bytes !== 6'd32 || out_last !== (k == 5)) begin errors++; $display("FAIL b2b_tail[%0d] got b%0d l%0h d%0h exp b32 l%0h d%0h", k, out_bytes, out_last, out_data, (k == 5), line_pat(20 + k)); end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained got %0h exp 0", out_valid); end
    endtask

    task automatic test_empty();
        checks++; if (job_ready !== 1'b1) begin errors++; $display("FAIL empty_ready_pre got %0h exp 1", job_ready); end
        start_job(19'h00040, 16'd0);
        checks++; if (job_done !== 1'b0 || job_ready !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL empty_cycle1 got d%0h r%0h q%0h exp d0 r0 q0", job_done, job_ready, mem_req); end
        tick();
        checks++; if (job_done !== 1'b1 || job_ready !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL empty_cycle2 got d%0h r%0h q%0h exp d1 r1 q0", job_done, job_ready, mem_req); end
        tick();
        checks++; if (job_done !== 1'b0) begin errors++; $display("FAIL empty_done_pulse got %0h exp 0", job_done); end
    endtask

    task automatic test_timeout();
        int w;
        int hi;
        start_job(19'h00200, 16'd64);
        wait_req(w);
        checks++; if (w !== 1) begin errors++; $display("FAIL to_req got %0d exp 1", w); end
        hi = 0;
        for (int i = 0; i < 40; i++) begin
            if (!mem_req) break;
            hi++;
            tick();
        end
        checks++; if (hi !== 16) begin errors++; $display("FAIL to_req_cycles got %0d exp 16", hi); end
        checks++; if (job_err !== 1'b1) begin errors++; $display("FAIL to_err got %0h exp 1", job_err); end
        tick();
        checks++; if (job_done !== 1'b1) begin errors++; $display("FAIL to_done got %0h exp 1", job_done); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL to_no_lines got %0h exp 0", out_valid); end
        tick();
        pulse_valid(line_pat(99));
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL to_stray_push got %0h exp 0", out_valid); end
        checks++; if (job_err !== 1'b1) begin errors++; $display("FAIL to_err_sticky got %0h exp 1", job_err); end
        start_job(19'h00000, 16'd0);
        checks++; if (job_err !== 1'b0) begin errors++; $display("FAIL to_err_clear got %0h exp 0", job_err); end
        tick();
        tick();
    endtask

    task automatic test_reset_midjob();
        int w;
        out_ready = 1'b0;
        start_job(19'h02000, 16'd128);
        for (int k = 0; k < 2; k++) begin
            wait_req(w);
            pulse_valid(line_pat(30 + k));
        end
        wait_req(w);
        checks++; if (w < 0 || out_valid !== 1'b1) begin errors++; $display("FAIL mid_setup got w%0d v%0h exp req and v1", w, out_valid); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (mem_req !== 1'b0 || out_valid !== 1'b0 || job_ready !== 1'b1) begin errors++; $display("FAIL mid_reset got q%0h v%0h r%0h exp q0 v0 r1", mem_req, out_valid, job_ready); end
        pulse_valid(line_pat(40));
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_late_valid got %0h exp 0", out_valid); end
    endtask

    initial begin
        rst       = 1'b1;
        job_valid = 1'b0;
        job_addr  = 19'h0;
        job_bytes = 16'd0;
        mem_valid = 1'b0;
        mem_data  = 256'd0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_wrap();
        test_back_to_back();
        test_empty();
        test_timeout();
        test_reset_midjob();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

endmodule
